ring_sched: RTL

RING_SCHED -- requirements
Module: ring_sched

---
 rtl/ring_pkg.sv | 33 +++
 rtl/ring_sched_if.sv | 36 +++
 rtl/ring_sched_gray2bin.sv | 18 +
 rtl/ring_sched.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the ring oscillator measurement scheduler:
// FSM state encoding and the helpers that size the internal counters.
package ring_pkg;

    // Measurement sequencer states, one ring at a time.
    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SNAP0,
        WINDOW,
        SNAP1,
        REPORT,
        NEXT
    } ring_state_t;

    // Larger of two integers, used to size the shared settle/window timer.
    function automatic int ring_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to index n items, never less than one so that a
    // single-ring build still has a legal ring id port.
    function automatic int ring_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of the down-counter that times both SETTLE and WINDOW. It is
    // loaded with (cycles - 1), so $clog2 of the larger length suffices.
    function automatic int ring_timer_w(input int settle, input int window);
        return ring_idx_w(ring_max(settle, window));
    endfunction

endpackage

// File: rtl/ring_sched_if.sv
// Control, ring-select and result handshake bundle of ring_sched.
// Signal names are written from the scheduler's point of view.
interface ring_sched_if
    import ring_pkg::*;
#(
    parameter int pRINGS = 4,
    parameter int pCNT_W = 16
) ();

    localparam int cIdW = ring_idx_w(pRINGS);

    logic              i_start;
    logic              i_abort;
    logic [pRINGS-1:0] i_mask;
    logic [pCNT_W-1:0] i_gray;
    logic              i_ready;
    logic [pRINGS-1:0] o_sel;
    logic              o_busy;
    logic              o_valid;
    logic [cIdW-1:0]   o_ring_id;
    logic [pCNT_W-1:0] o_count;
    logic              o_done;

    // Scheduler side.
    modport slave (
        input  i_start, i_abort, i_mask, i_gray, i_ready,
        output o_sel, o_busy, o_valid, o_ring_id, o_count, o_done
    );

    // Controller / result consumer side.
    modport master (
        output i_start, i_abort, i_mask, i_gray, i_ready,
        input  o_sel, o_busy, o_valid, o_ring_id, o_count, o_done
    );

endinterface

// File: rtl/ring_sched_gray2bin.sv
// Combinational Gray-to-binary converter. Binary bit i is the XOR of all
// Gray bits from i upward, computed here as a reduction of a shifted copy.
module gray2bin #(
    parameter int pW = 16
) (
    input  logic [pW-1:0] i_gray,
    output logic [pW-1:0] o_bin
);

    // Each output bit folds every Gray bit at or above its own position.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < pW; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/ring_sched.sv
// Ring oscillator measurement scheduler. Walks the rings selected by a
// mask, enables each in turn, lets it settle, takes two snapshots of its
// Gray-coded edge counter a fixed window apart and reports the difference
// over a valid/ready handshake. A done pulse closes every sweep, including
// aborted and empty ones.
module ring_sched
    import ring_pkg::*;
#(
    parameter int pRINGS  = 4,
    parameter int pCNT_W  = 16,
    parameter int pSETTLE = 16,
    parameter int pWINDOW = 256
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ring_sched_if.slave   bus
);

    localparam int cIdW  = ring_idx_w(pRINGS);
    localparam int cTmrW = ring_timer_w(pSETTLE, pWINDOW);

    // The timer counts down to zero, so a phase of N cycles loads N-1.
    localparam logic [cTmrW-1:0] cSettleLoad = cTmrW'(pSETTLE - 1);
    localparam logic [cTmrW-1:0] cWindowLoad = cTmrW'(pWINDOW - 1);

    ring_state_t       r_state;
    logic [pRINGS-1:0] r_pending;
    logic [pRINGS-1:0] r_sel;
    logic [cIdW-1:0]   r_cur;
    logic [cTmrW-1:0]  r_timer;
    logic [pCNT_W-1:0] r_c0;
    logic [pCNT_W-1:0] r_c1;
    logic [pCNT_W-1:0] r_count;
    logic [cIdW-1:0]   r_ring_id;
    logic              r_busy;
    logic              r_valid;
    logic              r_done;

    logic              w_any;
    logic [cIdW-1:0]   w_idx;
    logic [pRINGS-1:0] w_onehot;
    logic [pCNT_W-1:0] w_bin;

    // One converter serves both snapshots; the FSM decides which register
    // captures its output.
    gray2bin #(
        .pW (pCNT_W)
    ) u_gray2bin (
        .i_gray (bus.i_gray),
        .o_bin  (w_bin)
    );

    // Lowest-index pending ring, as an index and as a one-hot enable.
    always_comb begin
        w_any    = 1'b0;
        w_idx    = '0;
        w_onehot = '0;
        for (int i = 0; i < pRINGS; i++) begin
            if (r_pending[i] && !w_any) begin
                w_any       = 1'b1;
                w_idx       = cIdW'(i);
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Sweep sequencer with registered outputs. Abort overrides every
    // non-idle state, including a REPORT that is being accepted. The end
    // snapshot is latched as WINDOW closes so the two samples are exactly
    // pWINDOW cycles apart; SNAP1 then forms the wrapped difference.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_sel     <= '0;
            r_cur     <= '0;
            r_timer   <= '0;
            r_c0      <= '0;
            r_c1      <= '0;
            r_count   <= '0;
            r_ring_id <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE && bus.i_abort) begin
                r_state   <= IDLE;
                r_pending <= '0;
                r_sel     <= '0;
                r_timer   <= '0;
                r_busy    <= 1'b0;
                r_valid   <= 1'b0;
                r_done    <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.i_start) begin
                            r_pending <= bus.i_mask;
                            r_busy    <= 1'b1;
                            r_state   <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (w_any) begin
                            r_sel     <= w_onehot;
                            r_cur     <= w_idx;
                            r_pending <= r_pending & ~w_onehot;
                            r_timer   <= cSettleLoad;
                            r_state   <= SETTLE;
                        end else begin
                            r_sel   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    SETTLE: begin
                        if (r_timer == '0) begin
                            r_state <= SNAP0;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    SNAP0: begin
                        r_c0    <= w_bin;
                        r_timer <= cWindowLoad;
                        r_state <= WINDOW;
                    end
                    WINDOW: begin
                        if (r_timer == '0) begin
                            r_c1    <= w_bin;
                            r_state <= SNAP1;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    SNAP1: begin
                        r_count   <= r_c1 - r_c0;
                        r_ring_id <= r_cur;
                        r_valid   <= 1'b1;
                        r_state   <= REPORT;
                    end
                    REPORT: begin
                        if (bus.i_ready) begin
                            r_valid <= 1'b0;
                            r_sel   <= '0;
                            r_state <= NEXT;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_sel     = r_sel;
    assign bus.o_busy    = r_busy;
    assign bus.o_valid   = r_valid;
    assign bus.o_ring_id = r_ring_id;
    assign bus.o_count   = r_count;
    assign bus.o_done    = r_done;

endmodule
